fetch_cycle_bp: RTL and testbench
=================================

Name: fetch_cycle_bp

Overview:
Instruction fetch stage with an integrated dynamic branch predictor. It sits directly upstream of the decode stage.
- Owns the PC register and drives the instruction memory address.
- Predicts the next PC with a 2-bit-counter BHT plus a direct-mapped BTB.
- Registers the IF/ID pipeline outputs (InstrD, PCD, PCPlus4D, prediction info) that decode consumes.
- Execute-stage feedback trains the predictor and redirects fetch on a mispredict.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IDX_BITS, 4, log2 of the number of BHT/BTB entries (16 entries by default).

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  synchronous active-low reset.
StallF  in  1  hold PC.
StallD  in  1  hold IF/ID register.
FlushD  in  1  load bubble into IF/ID register.
InstrF  in  32  instruction read from IMEM at PCF (combinational).
PCF  out  32  current fetch PC / IMEM address.
RedirectE  in  1  execute resolved a mispredict or jalr; forces PC.
RedirectPCE  in  32  corrected PC.
UpdateE  in  1  a conditional branch resolved in execute; train predictor.
UpdatePCE  in  32  PC of the resolved branch.
UpdateTakenE  in  1  actual branch outcome.
UpdateTargetE  in  32  actual branch target.
InstrD  out  32  registered instruction.
PCD  out  32  registered PC.
PCPlus4D  out  32  registered PC+4.
PredTakenD  out  1  registered prediction for InstrD.
PredTargetD  out  32  registered predicted target (0 when not predicted taken).

Behaviour:
- Reset (rst==0 at posedge):
  - PCF=RESET_PC.
  - InstrD, PCD, PCPlus4D, PredTargetD = 0; PredTakenD=0.
  - All BHT counters=2'b01 (weakly not-taken); all BTB valid bits=0.
  - Reset overrides every other input, including mid-stream.
- Lookup, combinational on PCF:
  - idx = PCF[IDX_BITS+1:2]; tag = PCF[31:IDX_BITS+2].
  - hit = valid[idx] & (btb_tag[idx]==tag).
  - pred_taken = hit & bht[idx][1]; pred_target = btb_target[idx].
- Next PC, first match wins:
  1. RedirectE → RedirectPCE. Overrides StallF.
  2. StallF → hold PCF.
  3. pred_taken → pred_target.
  4. otherwise → PCF+4, with 32-bit wrap (0xFFFF_FFFC+4 = 0).
- IF/ID register, first match wins:
  1. reset → zeros.
  2. FlushD → zeros. FlushD beats StallD.
  3. StallD → hold.
  4. otherwise → InstrD=InstrF, PCD=PCF, PCPlus4D=PCF+4, PredTakenD=pred_taken, PredTargetD = pred_taken ? pred_target : 0.
- Predictor update on a posedge with UpdateE=1:
  - u = UpdatePCE[IDX_BITS+1:2].
  - BHT[u] saturates: +1 if UpdateTakenE (max 11), −1 otherwise (min 00).
  - If UpdateTakenE: BTB[u] ← {valid=1, tag=UpdatePCE[31:IDX_BITS+2], target=UpdateTargetE}. Not-taken leaves the BTB unchanged.
  - The BHT is untagged; aliasing between branches is permitted.
  - An update and a lookup of the same index in the same cycle: the lookup sees the pre-update value; the new value is visible next cycle.
  - Updates still occur while StallF/StallD are asserted.
- Latency: the predicted PC is applied on the next cycle (0-bubble taken prediction on a hit); InstrD is valid 1 cycle after PCF.

Optional Feature:
FETCH_BP_EN.
- Defined: BHT/BTB instantiated and behave as above.
- Undefined:
  - No predictor storage.
  - pred_taken is constant 0, so next PC is RedirectPCE, hold, or PCF+4.
  - PredTakenD=0 and PredTargetD=0 always.
  - Update* inputs are ignored.
  - All other behaviour is unchanged.

Test Plan:
1. rst=0 for 2 cycles, then rst=1 → PCF=0 during reset, InstrD=0, PredTakenD=0; afterwards PCF steps 0,4,8 and InstrD follows InstrF one cycle later.
2. At PCF=8, assert StallF=StallD=1 for 3 cycles → PCF stays 8 and InstrD is held. Then StallD=1 with FlushD=1 → InstrD=0, PCD=0.
3. UpdateE pulses twice with UpdatePCE=0x10, UpdateTakenE=1, UpdateTargetE=0x40 (BHT 01→10→11). Fetch reaches 0x10 → next PCF=0x40, PredTakenD=1, PredTargetD=0x40 alongside PCD=0x10.
4. RedirectE=1, RedirectPCE=0x100, StallF=1 in the same cycle → next PCF=0x100.
5. After test 3, fetch 0x10+(1<<(IDX_BITS+2)) = 0x50 → tag miss, PredTakenD=0, next PCF=0x54. Then train 0x10 not-taken twice → 0x10 predicts not-taken.
6. After test 3, assert rst=0 for one cycle mid-stream → PCF=RESET_PC, BTB cleared; fetching 0x10 then gives PredTakenD=0 and next PCF=0x14.

Source files
------------

// File: rtl/fetch_cycle_bp_if.sv
// Fetch-stage bus: pipeline control, IMEM read data, execute feedback and the
// registered IF/ID outputs consumed by decode.
//   master : the fetch stage (drives PCF and the IF/ID outputs)
//   slave  : the surrounding pipeline / IMEM / testbench
interface fetch_cycle_bp_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        RedirectE;
  logic [31:0] RedirectPCE;
  logic        UpdateE;
  logic [31:0] UpdatePCE;
  logic        UpdateTakenE;
  logic [31:0] UpdateTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        PredTakenD;
  logic [31:0] PredTargetD;

  modport master (
    input  StallF, StallD, FlushD, InstrF,
    input  RedirectE, RedirectPCE,
    input  UpdateE, UpdatePCE, UpdateTakenE, UpdateTargetE,
    output PCF, InstrD, PCD, PCPlus4D, PredTakenD, PredTargetD
  );

  modport slave (
    output StallF, StallD, FlushD, InstrF,
    output RedirectE, RedirectPCE,
    output UpdateE, UpdatePCE, UpdateTakenE, UpdateTargetE,
    input  PCF, InstrD, PCD, PCPlus4D, PredTakenD, PredTargetD
  );
endinterface

// File: rtl/fetch_cycle_bp.sv
// Instruction fetch stage with a 2-bit-counter BHT and direct-mapped BTB.
// Owns the PC, drives the IMEM address (PCF) and registers the IF/ID outputs.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-low reset
//   bus  : fetch_cycle_bp_if.master (stall/flush, InstrF, redirect, predictor
//          training, PCF and IF/ID outputs)
// Build option: define FETCH_BP_EN to instantiate the predictor; without it
// fetch always falls through to PC+4 (or redirect/hold) and Update* is ignored.
module fetch_cycle_bp #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IDX_BITS = 4
) (
  input logic              clk,
  input logic              rst,
  fetch_cycle_bp_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4d_q, pcplus4d_d;
  logic        pred_taken_d_q, pred_taken_d_d;
  logic [31:0] pred_target_d_q, pred_target_d_d;

  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_BP_EN
  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagW    = 30 - IDX_BITS;

  logic [1:0]         bht_q [Entries];
  logic [1:0]         bht_d [Entries];
  logic [Entries-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q [Entries];
  logic [TagW-1:0]    tag_d [Entries];
  logic [31:0]        tgt_q [Entries];
  logic [31:0]        tgt_d [Entries];

  logic [IDX_BITS-1:0] look_idx, upd_idx;
  logic [TagW-1:0]     look_tag;
  logic                hit;

  assign look_idx    = pc_q[IDX_BITS+1:2];
  assign look_tag    = pc_q[31:IDX_BITS+2];
  assign upd_idx     = bus.UpdatePCE[IDX_BITS+1:2];
  // Lookup reads the _q arrays, so a same-cycle update is seen next cycle.
  assign hit         = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign pred_taken  = hit && bht_q[look_idx][1];
  assign pred_target = tgt_q[look_idx];

  always_comb begin
    bht_d   = bht_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (bus.UpdateE) begin
      if (bus.UpdateTakenE) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = bus.UpdatePCE[31:IDX_BITS+2];
        tgt_d[upd_idx]   = bus.UpdateTargetE;
      end else if (bht_q[upd_idx] != 2'b00) begin
        bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  // Tags/targets need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(Entries); i++) bht_q[i] <= 2'b01;
      valid_q <= '0;
    end else begin
      bht_q   <= bht_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = 32'd0;
`endif

  always_comb begin
    // Next PC: redirect beats stall, stall beats prediction.
    if (bus.RedirectE)   pc_d = bus.RedirectPCE;
    else if (bus.StallF) pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
    else                 pc_d = pc_plus4;

    instr_d_d       = instr_d_q;
    pcd_d           = pcd_q;
    pcplus4d_d      = pcplus4d_q;
    pred_taken_d_d  = pred_taken_d_q;
    pred_target_d_d = pred_target_d_q;
    if (bus.FlushD) begin
      instr_d_d       = 32'd0;
      pcd_d           = 32'd0;
      pcplus4d_d      = 32'd0;
      pred_taken_d_d  = 1'b0;
      pred_target_d_d = 32'd0;
    end else if (!bus.StallD) begin
      instr_d_d       = bus.InstrF;
      pcd_d           = pc_q;
      pcplus4d_d      = pc_plus4;
      pred_taken_d_d  = pred_taken;
      pred_target_d_d = pred_taken ? pred_target : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q            <= RESET_PC;
      instr_d_q       <= 32'd0;
      pcd_q           <= 32'd0;
      pcplus4d_q      <= 32'd0;
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= 32'd0;
    end else begin
      pc_q            <= pc_d;
      instr_d_q       <= instr_d_d;
      pcd_q           <= pcd_d;
      pcplus4d_q      <= pcplus4d_d;
      pred_taken_d_q  <= pred_taken_d_d;
      pred_target_d_q <= pred_target_d_d;
    end
  end

  assign bus.PCF         = pc_q;
  assign bus.InstrD      = instr_d_q;
  assign bus.PCD         = pcd_q;
  assign bus.PCPlus4D    = pcplus4d_q;
  assign bus.PredTakenD  = pred_taken_d_q;
  assign bus.PredTargetD = pred_target_d_q;

endmodule

// File: tb/tb_fetch_cycle_bp.sv
module tb_fetch_cycle_bp;

`ifdef FETCH_BP_EN
  localparam bit BpEn = 1'b1;
`else
  localparam bit BpEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instr_d;
    logic [31:0] pcd;
    logic [31:0] pcp4d;
    logic        ptk;
    logic [31:0] ptgt;
  } exp_t;

  typedef struct {
    logic rst_n;
    logic stall_f;
    logic stall_d;
    logic flush_d;
    exp_t exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  vec_t vecs[9];

  fetch_cycle_bp_if bus ();

  fetch_cycle_bp #(
    .RESET_PC(32'h0000_0000),
    .IDX_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] imem(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // Combinational IMEM model.
  assign bus.InstrF = imem(bus.PCF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pcf, input logic [31:0] instr_d,
                              input logic [31:0] pcd, input logic [31:0] pcp4d,
                              input logic ptk, input logic [31:0] ptgt);
    exp_t e;
    e.pcf = pcf; e.instr_d = instr_d; e.pcd = pcd; e.pcp4d = pcp4d;
    e.ptk = ptk; e.ptgt = ptgt;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drv(input logic rst_n, input logic sf, input logic sd, input logic fl,
                     input logic re, input logic [31:0] rpc, input logic ue,
                     input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
    rst               = rst_n;
    bus.StallF        = sf;
    bus.StallD        = sd;
    bus.FlushD        = fl;
    bus.RedirectE     = re;
    bus.RedirectPCE   = rpc;
    bus.UpdateE       = ue;
    bus.UpdatePCE     = upc;
    bus.UpdateTakenE  = ut;
    bus.UpdateTargetE = utgt;
  endtask

  task automatic drv_norm();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic drv_redir(input logic [31:0] target);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, target, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Push the expectation, let one edge pass, compare on the falling edge.
  task automatic cycle(input exp_t e);
    exp_t h;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected one entry");
    end else begin
      h = sb.pop_front();
      cmp("PCF",         bus.PCF,         h.pcf);
      cmp("InstrD",      bus.InstrD,      h.instr_d);
      cmp("PCD",         bus.PCD,         h.pcd);
      cmp("PCPlus4D",    bus.PCPlus4D,    h.pcp4d);
      cmp("PredTakenD",  {31'd0, bus.PredTakenD}, {31'd0, h.ptk});
      cmp("PredTargetD", bus.PredTargetD, h.ptgt);
    end
  endtask

  initial begin
    logic [31:0] p;
    n_checks = 0;
    n_fail   = 0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Reset, sequential fetch, stall hold, flush over stall.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0)};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0)};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(32'h4, imem(32'h0), 32'h0, 32'h4, 1'b0, 32'h0)};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(32'h8, imem(32'h4), 32'h4, 32'h8, 1'b0, 32'h0)};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, mk(32'h8, imem(32'h4), 32'h4, 32'h8, 1'b0, 32'h0)};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, mk(32'h8, imem(32'h4), 32'h4, 32'h8, 1'b0, 32'h0)};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, mk(32'h8, imem(32'h4), 32'h4, 32'h8, 1'b0, 32'h0)};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, mk(32'hC, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0)};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(32'h10, imem(32'hC), 32'hC, 32'h10, 1'b0, 32'h0)};

    for (int i = 0; i < 9; i++) begin
      drv(vecs[i].rst_n, vecs[i].stall_f, vecs[i].stall_d, vecs[i].flush_d,
          1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      cycle(vecs[i].exp);
    end

    // Train 0x10 taken twice while both stages are stalled.
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1, 32'h40);
    cycle(mk(32'h10, imem(32'hC), 32'hC, 32'h10, 1'b0, 32'h0));
    cycle(mk(32'h10, imem(32'hC), 32'hC, 32'h10, 1'b0, 32'h0));
    p = BpEn ? 32'h40 : 32'h14;
    drv_norm();
    cycle(mk(p, imem(32'h10), 32'h10, 32'h14, BpEn, BpEn ? 32'h40 : 32'h0));

    // Redirect wins over StallF.
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(mk(32'h100, imem(p), p, p + 32'd4, 1'b0, 32'h0));

    // Same index, different tag: miss.
    drv_redir(32'h50);
    cycle(mk(32'h50, imem(32'h100), 32'h100, 32'h104, 1'b0, 32'h0));
    drv_norm();
    cycle(mk(32'h54, imem(32'h50), 32'h50, 32'h54, 1'b0, 32'h0));

    // Untrain 0x10 (11 -> 10 -> 01) while fetch keeps running.
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, 32'h0);
    cycle(mk(32'h58, imem(32'h54), 32'h54, 32'h58, 1'b0, 32'h0));
    cycle(mk(32'h5C, imem(32'h58), 32'h58, 32'h5C, 1'b0, 32'h0));
    drv_redir(32'h10);
    cycle(mk(32'h10, imem(32'h5C), 32'h5C, 32'h60, 1'b0, 32'h0));
    drv_norm();
    cycle(mk(32'h14, imem(32'h10), 32'h10, 32'h14, 1'b0, 32'h0));

    // Retrain taken, confirm prediction, then reset mid-stream clears the BTB.
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1, 32'h40);
    cycle(mk(32'h14, imem(32'h10), 32'h10, 32'h14, 1'b0, 32'h0));
    cycle(mk(32'h14, imem(32'h10), 32'h10, 32'h14, 1'b0, 32'h0));
    drv_redir(32'h10);
    cycle(mk(32'h10, imem(32'h14), 32'h14, 32'h18, 1'b0, 32'h0));
    drv_norm();
    cycle(mk(p, imem(32'h10), 32'h10, 32'h14, BpEn, BpEn ? 32'h40 : 32'h0));
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0));
    drv_redir(32'h10);
    cycle(mk(32'h10, imem(32'h0), 32'h0, 32'h4, 1'b0, 32'h0));
    drv_norm();
    cycle(mk(32'h14, imem(32'h10), 32'h10, 32'h14, 1'b0, 32'h0));

    // 32-bit wrap of PC+4.
    drv_redir(32'hFFFF_FFFC);
    cycle(mk(32'hFFFF_FFFC, imem(32'h14), 32'h14, 32'h18, 1'b0, 32'h0));
    drv_norm();
    cycle(mk(32'h0, imem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
